// File: rtl/key_pio_debounce.sv
// key_pio_debounce: memory-mapped key input port with per-channel debounce and edge-capture interrupt.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   reset_n     asynchronous active-low reset
//   address     register word select (0 DATA, 1 RISE_EN, 2 IRQ_MASK, 3 EDGE_CAP, 4 FALL_EN)
//   chipselect  slave select, qualifies write_n
//   write_n     active-low write strobe
//   writedata   write data, bits above WIDTH-1 ignored
//   in_port     raw asynchronous key inputs
//   readdata    registered read data, one cycle after address, upper bits zero
//   irq         level interrupt, OR of EDGE_CAP & IRQ_MASK
//
// Build option: define KEY_PIO_DEBOUNCE_EN to include the per-channel debounce
// counters; without it the debounced state is the synchronizer output registered once.
module key_pio_debounce #(
    parameter int   WIDTH           = 4,
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [WIDTH-1:0] sync1, sync2, state, state_q;
    logic [WIDTH-1:0] rise_en, fall_en, irq_mask, edge_cap, events, sel;
    logic             wr;
    logic             unused_writedata;

    assign wr = chipselect & ~write_n;
    assign unused_writedata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= {WIDTH{IDLE_LEVEL}};
            sync2 <= {WIDTH{IDLE_LEVEL}};
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

`ifdef KEY_PIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // The accepting edge is the one on which the count would reach DEBOUNCE_CYCLES.
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [CW-1:0] count;
        logic          q;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                count <= '0;
                q     <= IDLE_LEVEL;
            end else if (sync2[i] == q) begin
                count <= '0;
            end else if (count == LAST) begin
                count <= '0;
                q     <= sync2[i];
            end else begin
                count <= count + 1'b1;
            end
        end
        assign state[i] = q;
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= {WIDTH{IDLE_LEVEL}};
        else
            state <= sync2;
    end
`endif

    // Previous debounced state; resetting it to the idle level keeps reset
    // release from looking like an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= {WIDTH{IDLE_LEVEL}};
        else
            state_q <= state;
    end

    assign events = (state & ~state_q & rise_en) | (~state & state_q & fall_en);

    always_comb begin
        sel = address == 3'd0 ? state    :
              address == 3'd1 ? rise_en  :
              address == 3'd2 ? irq_mask :
              address == 3'd3 ? edge_cap :
              address == 3'd4 ? fall_en  : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_en  <= '0;
            fall_en  <= '0;
            irq_mask <= '0;
            edge_cap <= '0;
            readdata <= '0;
        end else begin
            if (wr && address == 3'd1) rise_en  <= writedata[WIDTH-1:0];
            if (wr && address == 3'd2) irq_mask <= writedata[WIDTH-1:0];
            if (wr && address == 3'd4) fall_en  <= writedata[WIDTH-1:0];
            // New events are OR-ed in after the write-1 clear so a coincident event wins.
            edge_cap <= (edge_cap & ~((wr && address == 3'd3) ? writedata[WIDTH-1:0] : '0)) | events;
            readdata <= 32'(sel);
        end
    end

    assign irq = |(edge_cap & irq_mask);
endmodule

// File: doc/key_pio_debounce.md
KEY_PIO_DEBOUNCE -- requirements
Module: key_pio_debounce

Interface
REQ-001 Parameter WIDTH, default 4: number of key input channels, 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable clk cycles needed to accept a level change, >=1.
REQ-003 Parameter IDLE_LEVEL, default 1'b1: reset value of the synchronizer and debounced state for every channel.
REQ-004 clk  input  1  system clock; all logic rising-edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 address  input  3  register word select.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-009 writedata  input  32  write data; bits above WIDTH-1 ignored.
REQ-010 in_port  input  WIDTH  raw asynchronous key inputs.
REQ-011 readdata  output  32  registered read data; bits above WIDTH-1 read 0.
REQ-012 irq  output  1  level interrupt.

Function
REQ-013 Register map: 0 DATA (RO, debounced state); 1 RISE_EN (RW); 2 IRQ_MASK (RW); 3 EDGE_CAP (RW1C); 4 FALL_EN (RW); 5-7 read 0, writes ignored.
REQ-014 readdata SHALL update every clk from the addressed register, 1-cycle latency, independent of chipselect.
REQ-015 Each channel SHALL pass through a 2-FF synchronizer before any other use.
REQ-016 Per-channel counter, width clog2(DEBOUNCE_CYCLES+1): increments while synced input != debounced state; clears when they are equal.
REQ-017 When the counter reaches DEBOUNCE_CYCLES, the debounced bit SHALL take the synced value on that edge and the counter SHALL clear.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES SHALL NOT change the debounced state; the counter restarts from 0 on every disagreement after agreement.
REQ-019 Rising event on channel i: debounced 0->1 and RISE_EN[i]=1. Falling event: 1->0 and FALL_EN[i]=1. Both enabled: either direction sets the capture bit.
REQ-020 Event on channel i SHALL set EDGE_CAP[i] on the clk edge after the debounced bit changes.
REQ-021 Write to EDGE_CAP SHALL clear exactly the bits written as 1; bits written 0 are unchanged.
REQ-022 Clear and new event on the same bit in the same cycle: set wins; the event is not lost.
REQ-023 irq = OR over i of (EDGE_CAP[i] & IRQ_MASK[i]), combinational from registers, no added latency.
REQ-024 Total latency from stable in_port change to DATA visible in readdata: 2 (sync) + DEBOUNCE_CYCLES + 1 (readdata) cycles.

Reset
REQ-025 On reset_n low, asynchronously: sync FFs and debounced state = {WIDTH{IDLE_LEVEL}}; counters, RISE_EN, FALL_EN, IRQ_MASK, EDGE_CAP, readdata = 0; irq = 0.
REQ-026 Reset asserted mid-count SHALL discard the partial count; no event is produced on reset release unless a change then completes a full debounce.

Configuration
REQ-027 Macro KEY_PIO_DEBOUNCE_EN defined: debounce counters present per REQ-016..018.
REQ-028 Macro KEY_PIO_DEBOUNCE_EN undefined: no counters; debounced state = synchronizer output registered once (change seen after 3 cycles); DEBOUNCE_CYCLES ignored; all other behaviour unchanged.

Verification
REQ-029 WIDTH=4, DEBOUNCE_CYCLES=8, IDLE_LEVEL=1: hold in_port=4'hF after reset -> DATA reads 4'hF, EDGE_CAP 0, irq 0.
REQ-030 FALL_EN=1, IRQ_MASK=1; in_port[0] pulses low 5 cycles -> no change; held low 20 cycles -> DATA=4'hE, EDGE_CAP=4'h1, irq=1 at cycle 2+8+1 after the drop.
REQ-031 EDGE_CAP=4'h3 set; write 4'h1 to address 3 -> EDGE_CAP=4'h2; irq follows IRQ_MASK.
REQ-032 Write-1 clear of bit 1 in the same cycle its debounced edge completes -> EDGE_CAP[1] stays 1.
REQ-033 RISE_EN=FALL_EN=4'h4; toggle in_port[2] low then high, each held 20 cycles -> EDGE_CAP[2] set after each transition; re-clear between them.
REQ-034 Assert reset_n during count 5 of 8 on channel 3, then release -> no EDGE_CAP bit set; DATA = IDLE_LEVEL until a fresh full debounce completes.
